// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: owns the PC, fetches a 32-bit instruction as 32/MEMW big-endian
// memory beats and hands it to decode through a valid/ready handshake, with redirects.
module ifetch_unit #(
  parameter int            MEMW     = 8,
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [AW-1:0]   mem_adr,
  input  logic            mem_ready,
  input  logic [MEMW-1:0] mem_rdata,
  output logic [31:0]     instr,
  output logic [AW-1:0]   instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            redir,
  input  logic [AW-1:0]   redir_pc
);

  localparam int            BEATS = 32 / MEMW;
  localparam logic [AW-1:0] STEP  = AW'(MEMW / 8);
  localparam logic [1:0]    LAST  = 2'(BEATS - 1);

  generate
    if (!(MEMW == 8 || MEMW == 16 || MEMW == 32) || (RESET_PC[1:0] != 2'b00)) begin : g_bad_param
      $error("ifetch_unit: MEMW must be 8, 16 or 32 and RESET_PC word aligned");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] fadr_q, fadr_d;
  logic [1:0]    beat_q, beat_d;
  logic [31:0]   instr_q, instr_d;
  logic [AW-1:0] instr_pc_q, instr_pc_d;
  logic          instr_valid_q, instr_valid_d;

  // Redirect targets are forced word aligned, so the low address bits are dropped.
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redir_pc[1:0];

  always_comb begin
    state_d       = state_q;
    fadr_d        = fadr_q;
    beat_d        = beat_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_q == 2'(k)) instr_d[31-k*MEMW -: MEMW] = mem_rdata;
          end
          fadr_d = fadr_q + STEP;
          if (beat_q == 2'd0) instr_pc_d = fadr_q;
          if (beat_q == LAST) begin
            state_d       = HOLD;
            beat_d        = 2'd0;
            instr_valid_d = 1'b1;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          state_d       = FETCH;
          instr_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    // A redirect wins over everything; a beat completing in the same cycle is thrown away.
    if (redir) begin
      state_d       = FETCH;
      fadr_d        = {redir_pc[AW-1:2], 2'b00};
      beat_d        = 2'd0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      fadr_q        <= RESET_PC;
      beat_q        <= 2'd0;
      instr_q       <= 32'h0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fadr_q        <= fadr_d;
      beat_q        <= beat_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign mem_req     = (state_q == FETCH);
  assign mem_adr     = fadr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Parametrised instruction-fetch unit for the multicycle core. It owns the program counter and a fetch FSM, issues one or more memory beats of MEMW bits, and assembles a 32-bit instruction big-endian (first beat to instr[31:...]). It presents the result to the decode/control stage through a valid/ready handshake and accepts branch/jump redirects. It replaces the four per-byte instruction registers and the PC register of the 8-bit datapath, and generalises them to 8/16/32-bit memory with wait states.

## Interface
Parameters:
- MEMW, 8, memory data width; legal values 8, 16, 32 only; other values are an elaboration error. BEATS = 32/MEMW.
- AW, 8, byte-address width of PC and memory address.
- RESET_PC, 0, PC after reset; low 2 bits must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  beat request; held high until the beat completes.
- mem_adr  out  AW  byte address of the current beat.
- mem_ready  in  1  beat completes in a cycle with mem_req&mem_ready.
- mem_rdata  in  MEMW  beat data; sampled only on beat completion.
- instr  out  32  assembled instruction.
- instr_pc  out  AW  byte address of the first beat of instr.
- instr_valid  out  1  instr/instr_pc are valid.
- instr_ready  in  1  consumer accepts in a cycle with instr_valid&instr_ready.
- redir  in  1  redirect request (branch/jump/exception).
- redir_pc  in  AW  redirect target.

## Operation
- States: IDLE, FETCH, HOLD. Reset enters IDLE with fadr=RESET_PC, beat=0, instr=0, instr_pc=0, instr_valid=0, mem_req=0, mem_adr=RESET_PC.
- IDLE: next edge -> FETCH unconditionally (first request one cycle after reset release).
- FETCH: mem_req=1, mem_adr=fadr. On beat completion: beat k (0-based) data stored to instr[31-k*MEMW -: MEMW]; fadr += MEMW/8 mod 2^AW; at k=0, instr_pc <= fadr. If k=BEATS-1 -> HOLD, beat<=0, instr_valid<=1; else beat++.
- HOLD: mem_req=0, instr_valid=1, instr stable. On instr_valid&instr_ready -> FETCH, instr_valid<=0. No prefetch: single instruction buffer.
- Redirect (highest priority, any state incl. IDLE): fadr <= {redir_pc[AW-1:2],2'b00} (misaligned bits silently cleared), beat<=0, instr_valid<=0, state<=FETCH. A beat completing in the same cycle is discarded (no write to instr, no fadr increment). A handshake in HOLD in the same cycle counts as accepted by the consumer; the unit still obeys the redirect.
- Partial instr contents during FETCH are undefined to the consumer; only valid when instr_valid=1.
- Address wraps mod 2^AW; no error on wrap.
- mem_req, mem_adr, instr_valid are functions of registered state only (no combinational path from mem_ready, instr_ready, or redir to any output).

## Timing
- Reset asynchronous: outputs take reset values immediately on reset assertion, irrespective of clk.
- Zero wait states: instruction valid BEATS cycles after entering FETCH; with instr_ready=1 throughput is one instruction per BEATS+1 cycles (MEMW=8: 5; MEMW=16: 3; MEMW=32: 2).
- Each wait cycle (mem_req=1, mem_ready=0) adds one cycle; mem_adr held constant across it.
- Redirect in cycle t: first request to the new target in cycle t+1; instr_valid=0 in t+1.
- instr_ready low in HOLD: instr, instr_pc, instr_valid held indefinitely.
- Reset asserted mid-fetch: partially assembled instruction discarded; after release, fetch restarts at RESET_PC via IDLE.

## Test plan
- MEMW=8, RESET_PC=0, mem_ready=1, instr_ready=1, memory bytes 8C 43 00 05 at 0..3 -> mem_adr 0,1,2,3 on consecutive cycles from 1 cycle after reset release; instr=0x8C430005, instr_pc=0 valid the next cycle; next request mem_adr=4 one cycle later.
- MEMW=8, mem_ready low 2 cycles on beat 2 -> mem_adr holds 2 for 3 cycles; instr_valid 2 cycles later than zero-wait case; value unchanged.
- MEMW=32, instr_ready low 5 cycles after first valid -> instr_valid and instr held 5 cycles, mem_req=0 throughout; after acceptance mem_adr=4.
- MEMW=16, redir=1 redir_pc=0x41 on the cycle beat 0 completes -> beat discarded; next cycle mem_req=1, mem_adr=0x40; instr_pc=0x40 on resulting instruction.
- MEMW=8, AW=8, redirect to 0xFC -> beats at FC,FD,FE,FF, instr_pc=0xFC, next fetch at 0x00.
- Assert reset asynchronously mid-beat 1 -> mem_req=0, instr_valid=0 immediately; after release refetch from RESET_PC.
